prng_xy_gen: RTL and testbench
==============================

Name: prng_xy_gen

Overview:
- Parametrised successor to the counter-based 8-bit X/Y pseudo-random coordinate generator.
- Produces a stream of (x, y) sample pairs of width W from a 2W-bit internal state.
- Two modes: counter-sum (the existing sequence, generalised to width W) and Galois LFSR.
- Adds a seed/mode load, a valid/ready output handshake with backpressure, an in-period step index and a period-wrap flag. Feeds downstream plotting/stat blocks.

Parameters:
- W, 8, coordinate width; internal state and step index are 2W bits.
- LFSR_TAPS, 16'hB400, 2W-bit Galois feedback mask (maximal-length for the default W).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  generation enable
- seed_load  in  1  load seed and mode (one-cycle strobe)
- seed  in  2W  initial state
- mode_in  in  1  0 = counter-sum, 1 = LFSR; sampled only on seed_load
- out_valid  out  1  sample present
- out_ready  in  1  downstream accepts sample
- x  out  W  sample X
- y  out  W  sample Y
- step  out  2W  index of the sample within the current period
- wrap  out  1  sample is the last one of the period

Behaviour:
- Internal registers: state s (2W), start (2W), mode (1), step_cnt (2W).
- Reset (async, rst_n=0):
  - s, start, mode, step_cnt = 0.
  - x, y, step = 0; out_valid = 0; wrap = 0.
- Output mapping, computed combinationally from the current s; hi = s[2W-1:W], lo = s[W-1:0]:
  - Counter mode: x = (hi+lo) mod 2^W; y = (hi+2*lo) mod 2^W. Next s = s+1 mod 2^(2W).
  - LFSR mode: x = hi; y = lo. Next s = (s>>1) XOR (s[0] ? LFSR_TAPS : 0).
- fire = en && !seed_load && (!out_valid || out_ready).
- On fire:
  - x, y, step (= step_cnt) and wrap (= next s == start) are registered.
  - s advances and out_valid is set to 1.
  - step_cnt increments; if the fired sample has wrap=1, step_cnt becomes 0 instead.
- Latency: the first sample appears one cycle after the first fire.
- Handshake:
  - With out_valid=1 and out_ready=0, x, y, step and wrap hold stable and s does not advance.
  - A beat transfers on out_valid && out_ready. If no new fire happens in that cycle, out_valid clears.
  - Back-to-back throughput is one sample per cycle while en=1 and out_ready=1.
- en=0: no new samples; a pending sample stays valid until accepted.
- seed_load (priority over fire):
  - mode <= mode_in.
  - s and start <= seed, except that seed==0 with mode_in=1 is replaced by 1 (LFSR lock-up avoidance).
  - step_cnt <= 0 and out_valid <= 0; any pending unaccepted sample is discarded.
- Period:
  - Counter mode: 2^(2W) samples.
  - LFSR mode: 2^(2W)-1 samples with maximal taps. wrap is asserted on the sample whose successor state equals start.
- All arithmetic is unsigned and truncated to W bits; step_cnt wraps naturally at 2^(2W).
- Reset mid-stream returns to the reset state immediately and asynchronously. Generation resumes in counter mode from s=0.

Decomposition:
- Shared package prng_pkg:
  - mode encoding constants MODE_CNT = 0 and MODE_LFSR = 1.
  - default taps constant PRNG_TAPS_16 = 16'hB400.
- One combinational sub-module, prng_step_logic (params W, LFSR_TAPS):
  - inputs: s, mode.
  - outputs: next_s, x_nxt, y_nxt.
- The top level holds the registers, the handshake, the seed sanitising and the wrap compare.

Test Plan:
1. Reset, W=8, en=1, out_ready=1 -> samples (step,x,y): (0,0,0), (1,1,2), (2,2,4). At step 300 (s=0x012C): x=45, y=89.
2. Counter mode run to the end of the period -> step 65535: x=254, y=253, wrap=1. The next sample is step 0, x=0, y=0, wrap=0.
3. seed_load with seed=16'hACE1, mode_in=1, then en=1 -> first sample x=0xAC, y=0xE1. Second sample x=0xE2, y=0x70.
4. LFSR mode, seed=0 -> treated as 1. First sample x=0x00, y=0x01. Second sample x=0xB4, y=0x00.
5. Counter mode, out_ready low for 3 cycles at step 5 -> x=5, y=10, step=5 held stable with out_valid=1. After out_ready rises, step 6 follows on the next cycle.
6. rst_n pulsed low mid-cycle at step 1000 -> out_valid, x, y, step and wrap go to 0 without waiting for a clock edge. After release, the first sample is step 0 in counter mode.

Source files
------------

// File: rtl/prng_xy_gen_pkg.sv
// Shared definitions for the X/Y pseudo-random coordinate generator:
// mode encodings and the default Galois feedback mask for W = 8.
package prng_pkg;

  // Generation mode, captured on seed_load
  localparam logic MODE_CNT  = 1'b0;  // counter-sum sequence
  localparam logic MODE_LFSR = 1'b1;  // Galois LFSR sequence

  // Maximal-length Galois mask for a 16-bit state (x^16 + x^14 + x^13 + x^11 + 1)
  localparam logic [15:0] PRNG_TAPS_16 = 16'hB400;

endpackage

// File: rtl/prng_xy_gen_if.sv
// Output stream of the coordinate generator: one (x, y) sample per beat,
// tagged with its in-period step index and an end-of-period flag.
// Transfer happens on out_valid && out_ready.
interface prng_xy_gen_if #(
  parameter int W = 8
) ();

  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic [2*W-1:0] step;
  logic           wrap;

  // Producer side (the generator)
  modport master (
    output out_valid,
    output x,
    output y,
    output step,
    output wrap,
    input  out_ready
  );

  // Consumer side (plotting / statistics block)
  modport slave (
    input  out_valid,
    input  x,
    input  y,
    input  step,
    input  wrap,
    output out_ready
  );

endinterface

// File: rtl/prng_step_logic.sv
// Pure combinational step function of the generator. From the current 2W-bit
// state it derives the successor state and the (x, y) sample that the state
// maps to. hi/lo are the upper and lower W-bit halves of the state.
module prng_step_logic
  import prng_pkg::*;
#(
  parameter int             W         = 8,
  parameter logic [2*W-1:0] LFSR_TAPS = (2*W)'(PRNG_TAPS_16)
) (
  input  logic [2*W-1:0] s_i,
  input  logic           mode_i,
  output logic [2*W-1:0] next_s_o,
  output logic [W-1:0]   x_nxt_o,
  output logic [W-1:0]   y_nxt_o
);

  logic [W-1:0]   hi_s;
  logic [W-1:0]   lo_s;
  logic [2*W-1:0] fb_mask_s;

  assign hi_s = s_i[2*W-1:W];
  assign lo_s = s_i[W-1:0];

  // Galois feedback applies the tap mask only when the bit shifted out is 1
  assign fb_mask_s = s_i[0] ? LFSR_TAPS : {(2*W){1'b0}};

  // Successor state and sample mapping for the selected mode
  always_comb begin
    next_s_o = s_i;
    x_nxt_o  = {W{1'b0}};
    y_nxt_o  = {W{1'b0}};
    case (mode_i)
      MODE_LFSR: begin
        // The LFSR state is shown raw: upper half as X, lower half as Y
        next_s_o = (s_i >> 1) ^ fb_mask_s;
        x_nxt_o  = hi_s;
        y_nxt_o  = lo_s;
      end
      MODE_CNT: begin
        // Counter-sum sequence; sums truncate to W bits by assignment width
        next_s_o = s_i + (2*W)'(1);
        x_nxt_o  = hi_s + lo_s;
        y_nxt_o  = hi_s + (lo_s << 1);
      end
      default: begin
        next_s_o = s_i;
        x_nxt_o  = {W{1'b0}};
        y_nxt_o  = {W{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/prng_xy_gen.sv
// X/Y pseudo-random coordinate generator with seed/mode load and a
// valid/ready output stream. The state register walks either the
// counter-sum sequence or a Galois LFSR; each produced sample carries its
// index within the current period and a flag marking the period's last sample.
module prng_xy_gen
  import prng_pkg::*;
#(
  parameter int             W         = 8,
  parameter logic [2*W-1:0] LFSR_TAPS = (2*W)'(PRNG_TAPS_16)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            seed_load,
  input  logic [2*W-1:0]  seed,
  input  logic            mode_in,
  prng_xy_gen_if.master   out_if
);

  // Generator state
  logic [2*W-1:0] s_q,        s_d;
  logic [2*W-1:0] start_q,    start_d;
  logic           mode_q,     mode_d;
  logic [2*W-1:0] step_cnt_q, step_cnt_d;

  // Registered output sample
  logic           valid_q,    valid_d;
  logic [W-1:0]   x_q,        x_d;
  logic [W-1:0]   y_q,        y_d;
  logic [2*W-1:0] step_q,     step_d;
  logic           wrap_q,     wrap_d;

  // Combinational helpers
  logic [2*W-1:0] next_s_s;
  logic [W-1:0]   x_nxt_s;
  logic [W-1:0]   y_nxt_s;
  logic [2*W-1:0] seed_san_s;
  logic           fire_s;
  logic           accept_s;
  logic           wrap_nxt_s;

  prng_step_logic #(
    .W         (W),
    .LFSR_TAPS (LFSR_TAPS)
  ) u_step (
    .s_i      (s_q),
    .mode_i   (mode_q),
    .next_s_o (next_s_s),
    .x_nxt_o  (x_nxt_s),
    .y_nxt_o  (y_nxt_s)
  );

  // An all-zero LFSR state never leaves zero, so an LFSR seed of 0 becomes 1
  assign seed_san_s = ((seed == {(2*W){1'b0}}) && (mode_in == MODE_LFSR))
                      ? (2*W)'(1) : seed;

  // A new sample is produced when enabled, not loading, and the output slot
  // is either empty or being emptied this cycle
  assign fire_s   = en && !seed_load && (!valid_q || out_if.out_ready);
  assign accept_s = valid_q && out_if.out_ready;

  // The sample is the period's last when its successor is the start state
  assign wrap_nxt_s = (next_s_s == start_q);

  // Next-state selection: seed load beats generation, generation beats drain
  always_comb begin
    s_d        = s_q;
    start_d    = start_q;
    mode_d     = mode_q;
    step_cnt_d = step_cnt_q;
    valid_d    = valid_q;
    x_d        = x_q;
    y_d        = y_q;
    step_d     = step_q;
    wrap_d     = wrap_q;
    if (seed_load) begin
      // Restart the period; any pending sample is dropped
      mode_d     = mode_in;
      s_d        = seed_san_s;
      start_d    = seed_san_s;
      step_cnt_d = {(2*W){1'b0}};
      valid_d    = 1'b0;
    end else if (fire_s) begin
      x_d     = x_nxt_s;
      y_d     = y_nxt_s;
      step_d  = step_cnt_q;
      wrap_d  = wrap_nxt_s;
      s_d     = next_s_s;
      valid_d = 1'b1;
      if (wrap_nxt_s) begin
        step_cnt_d = {(2*W){1'b0}};
      end else begin
        step_cnt_d = step_cnt_q + (2*W)'(1);
      end
    end else if (accept_s) begin
      // Beat consumed and nothing new to replace it
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q        <= {(2*W){1'b0}};
      start_q    <= {(2*W){1'b0}};
      mode_q     <= MODE_CNT;
      step_cnt_q <= {(2*W){1'b0}};
      valid_q    <= 1'b0;
      x_q        <= {W{1'b0}};
      y_q        <= {W{1'b0}};
      step_q     <= {(2*W){1'b0}};
      wrap_q     <= 1'b0;
    end else begin
      s_q        <= s_d;
      start_q    <= start_d;
      mode_q     <= mode_d;
      step_cnt_q <= step_cnt_d;
      valid_q    <= valid_d;
      x_q        <= x_d;
      y_q        <= y_d;
      step_q     <= step_d;
      wrap_q     <= wrap_d;
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.x         = x_q;
  assign out_if.y         = y_q;
  assign out_if.step      = step_q;
  assign out_if.wrap      = wrap_q;

endmodule

// File: tb/tb_prng_xy_gen.sv
// Scoreboard bench for prng_xy_gen (W = 8). Stimulus pushes hand-computed
// samples tagged with the absolute beat number they must appear at; a
// monitor counts accepted beats and checks tagged ones as they go by.
module tb_prng_xy_gen;
  import prng_pkg::*;

  localparam int W = 8;

  typedef struct {
    int          idx;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] step;
    logic        wrap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        seed_load;
  logic [15:0] seed;
  logic        mode_in;

  exp_t exp_q[$];
  exp_t mon_e;
  int   beat_cnt = 0;
  int   checks   = 0;
  int   errors   = 0;
  int   base;
  int   n;

  prng_xy_gen_if #(.W(W)) bus ();

  prng_xy_gen #(
    .W         (W),
    .LFSR_TAPS (16'hB400)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .seed_load (seed_load),
    .seed      (seed),
    .mode_in   (mode_in),
    .out_if    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input logic [7:0] x, input logic [7:0] y,
                      input logic [15:0] st, input logic wr);
    exp_t e;
    e.idx = idx; e.x = x; e.y = y; e.step = st; e.wrap = wr;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input int target, input int budget);
    int k;
    k = 0;
    while (beat_cnt < target && k < budget) begin
      tick();
      k++;
    end
    check($sformatf("beat_budget_%0d", target), 64'(beat_cnt >= target), 64'd1);
  endtask

  task automatic drain();
    en = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_seed(input logic [15:0] sd, input logic md);
    seed_load = 1'b1;
    seed      = sd;
    mode_in   = md;
    tick();
    seed_load = 1'b0;
    tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_x"},     64'(bus.x),         64'd0);
    check({tag, "_y"},     64'(bus.y),         64'd0);
    check({tag, "_step"},  64'(bus.step),      64'd0);
    check({tag, "_wrap"},  64'(bus.wrap),      64'd0);
  endtask

  // Monitor: count transferred beats, compare those the stimulus tagged
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() > 0 && exp_q[0].idx == beat_cnt) begin
        mon_e = exp_q.pop_front();
        check($sformatf("beat%0d_xy_step_wrap", beat_cnt),
              64'({bus.x, bus.y, bus.step, bus.wrap}),
              64'({mon_e.x, mon_e.y, mon_e.step, mon_e.wrap}));
      end
      beat_cnt++;
    end
  end

  initial begin
    rst_n         = 1'b0;
    en            = 1'b0;
    seed_load     = 1'b0;
    seed          = 16'h0000;
    mode_in       = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    check_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Counter mode from reset, through the full 65536-sample period and one past
    base = beat_cnt;
    push(base + 0,     8'd0,   8'd0,   16'd0,     1'b0);
    push(base + 1,     8'd1,   8'd2,   16'd1,     1'b0);
    push(base + 2,     8'd2,   8'd4,   16'd2,     1'b0);
    push(base + 300,   8'd45,  8'd89,  16'd300,   1'b0);
    push(base + 65535, 8'd254, 8'd253, 16'd65535, 1'b1);
    push(base + 65536, 8'd0,   8'd0,   16'd0,     1'b0);
    en = 1'b1;
    wait_beats(base + 65537, 66000);
    drain();

    // LFSR seeded with 0xACE1
    do_seed(16'hACE1, MODE_LFSR);
    base = beat_cnt;
    push(base + 0, 8'hAC, 8'hE1, 16'd0, 1'b0);
    push(base + 1, 8'hE2, 8'h70, 16'd1, 1'b0);
    en = 1'b1;
    wait_beats(base + 2, 20);
    drain();

    // LFSR with zero seed is promoted to 1
    do_seed(16'h0000, MODE_LFSR);
    base = beat_cnt;
    push(base + 0, 8'h00, 8'h01, 16'd0, 1'b0);
    push(base + 1, 8'hB4, 8'h00, 16'd1, 1'b0);
    en = 1'b1;
    wait_beats(base + 2, 20);
    drain();

    // Backpressure at step 5 in counter mode
    do_seed(16'h0000, MODE_CNT);
    base = beat_cnt;
    push(base + 5, 8'd5, 8'd10, 16'd5, 1'b0);
    push(base + 6, 8'd6, 8'd12, 16'd6, 1'b0);
    en = 1'b1;
    n = 0;
    while (!(bus.out_valid === 1'b1 && bus.step === 16'd5) && n < 20) begin
      tick();
      n++;
    end
    check("bp_reach_step5", 64'(n < 20), 64'd1);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp_hold%0d_valid", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("bp_hold%0d_xy_step", i), 64'({bus.x, bus.y, bus.step}),
            64'({8'd5, 8'd10, 16'd5}));
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_next_valid", 64'(bus.out_valid), 64'd1);
    check("bp_next_step",  64'(bus.step),      64'd6);
    drain();

    // Asynchronous reset in mid-cycle during an LFSR run at step 1000
    do_seed(16'h1234, MODE_LFSR);
    en = 1'b1;
    n = 0;
    while (!(bus.out_valid === 1'b1 && bus.step === 16'd1000) && n < 1100) begin
      tick();
      n++;
    end
    check("rst_reach_step1000", 64'(n < 1100), 64'd1);
    #2;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    check_zero("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    base = beat_cnt;
    push(base + 0, 8'd0, 8'd0, 16'd0, 1'b0);
    push(base + 1, 8'd1, 8'd2, 16'd1, 1'b0);
    en = 1'b1;
    wait_beats(base + 2, 20);
    drain();

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
